// File: rtl/y_run_ctrl.sv
// Run/step sequencer for the yChip core: loads the entry point, gates retirement
// with a clock-enable (free-run or single-step) and traces every retired (ins, wb) pair.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, chip held
// LOAD      | one cycle: chip PC loads chip_entry
// RUN       | free-run, retires every cycle unless the trace FIFO stalls
// STEP_WAIT | retires one instruction per step pulse
// HALT      | run finished (halt instruction or cycle limit), outputs hold
module y_run_ctrl #(
    parameter int unsigned MAX_CYCLES  = 43,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter logic [31:0] HALT_INS    = 32'h0000_000C
) (
    input  logic                          clk,
    input  logic                          INT,
    input  logic                          start,
    input  logic                          run_mode,
    input  logic                          step,
    input  logic [31:0]                   entry,
    input  logic [31:0]                   ins,
    input  logic [31:0]                   wb,
    output logic                          chip_INT,
    output logic [31:0]                   chip_entry,
    output logic                          chip_en,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    halt_cause,
    output logic [15:0]                   cycle_cnt,
    output logic                          tr_valid,
    input  logic                          tr_ready,
    output logic [31:0]                   tr_ins,
    output logic [31:0]                   tr_wb,
    output logic [$clog2(TRACE_DEPTH):0]  tr_count
);
    localparam int unsigned AW = $clog2(TRACE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP_WAIT,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   entry_q, entry_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic [15:0]   cnt_inc;

    logic [31:0]   mem_ins_q [TRACE_DEPTH];
    logic [31:0]   mem_wb_q  [TRACE_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, pop, push;

    assign full    = (count_q == (AW+1)'(TRACE_DEPTH));
    assign pop     = (count_q != '0) && tr_ready;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        chip_en = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    entry_d = entry;
                    cnt_d   = '0;
                    cause_d = 2'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                chip_en = 1'b1;
                state_d = run_mode ? S_RUN : S_STEP_WAIT;
            end
            S_RUN, S_STEP_WAIT: begin
                // A pop in the same cycle frees the slot, so a full FIFO only stalls without one
                chip_en = ((state_q == S_RUN) || step) && (!full || tr_ready);
                state_d = run_mode ? S_RUN : S_STEP_WAIT;
                if (chip_en) begin
                    push  = 1'b1;
                    cnt_d = cnt_inc;
                    if (ins == HALT_INS) begin
                        state_d = S_HALT;
                        cause_d = 2'd1;
                    end else if (32'(cnt_inc) == MAX_CYCLES) begin
                        state_d = S_HALT;
                        cause_d = 2'd2;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (INT) begin
            chip_en = 1'b0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (pop && !push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ins_q[wr_ptr_q] <= ins;
            mem_wb_q[wr_ptr_q]  <= wb;
        end
    end

    assign chip_INT   = INT || (state_q == S_LOAD);
    assign chip_entry = entry_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_STEP_WAIT);
    assign done       = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign cycle_cnt  = cnt_q;
    assign tr_valid   = (count_q != '0);
    assign tr_ins     = mem_ins_q[rd_ptr_q];
    assign tr_wb      = mem_wb_q[rd_ptr_q];
    assign tr_count   = count_q;

endmodule

// File: doc/y_run_ctrl.md
Name: y_run_ctrl

Overview:
- Run/step sequencer for the yChip single-cycle processor.
- Loads the entry point through the chip's INT input, then gates instruction retirement with a clock-enable, either free-running or single-stepping.
- Stops on a halt instruction or a cycle limit.
- Captures each retired (ins, wb) pair into a trace FIFO with a valid/ready drain. The bench or debug port reads the FIFO instead of sampling the chip directly.

Parameters:
- MAX_CYCLES, 43: retired-instruction limit per run; 1..65535.
- TRACE_DEPTH, 8: trace FIFO entries; power of 2, minimum 2.
- HALT_INS, 32'h0000000C: instruction word that terminates a run (syscall).

Ports:
- clk, input, 1: single clock, rising edge.
- INT, input, 1: synchronous active-high reset.
- start, input, 1: one-cycle pulse; begins a run from entry.
- run_mode, input, 1: 1 = free-run, 0 = single-step.
- step, input, 1: one-cycle pulse; retires one instruction in single-step.
- entry, input, 32: entry point; sampled on start.
- ins, input, 32: current instruction from the chip.
- wb, input, 32: current write-back value from the chip.
- chip_INT, output, 1: drives the chip INT input (loads PC from chip_entry).
- chip_entry, output, 32: drives the chip entryPoint input.
- chip_en, output, 1: clock-enable for the chip; the chip advances only on edges where it is 1.
- busy, output, 1: run in progress (LOAD/RUN/STEP_WAIT).
- done, output, 1: run finished (HALT state).
- halt_cause, output, 2: 0 none, 1 halt instruction, 2 cycle limit.
- cycle_cnt, output, 16: instructions retired this run.
- tr_valid, output, 1: trace FIFO non-empty.
- tr_ready, input, 1: consumer pop.
- tr_ins, output, 32: head entry, instruction word.
- tr_wb, output, 32: head entry, write-back value.
- tr_count, output, log2(TRACE_DEPTH)+1: FIFO occupancy.

Behaviour:

Reset (INT=1 at an edge):
- State goes to IDLE; FIFO is emptied.
- cycle_cnt=0, halt_cause=0, chip_entry=0.
- chip_en=0, busy=0, done=0, tr_valid=0.
- chip_INT = INT OR (state==LOAD), so the chip is also held in load while reset is asserted.
- Reset overrides every other input in every state, including mid-run.

States:
- IDLE: busy=0.
  - On start: latch entry into chip_entry, clear cycle_cnt and halt_cause, go to LOAD.
- LOAD: exactly one cycle. chip_INT=1, chip_en=1, so the PC loads chip_entry at this edge; this is not a retirement.
  - Next state is RUN if run_mode=1, else STEP_WAIT.
- RUN: chip_en=1 every cycle unless the FIFO is full and no pop occurs this cycle (backpressure stall, chip_en=0).
  - run_mode=0 sampled in RUN goes to STEP_WAIT after the current cycle.
- STEP_WAIT: chip_en = step AND (FIFO not full OR tr_ready).
  - A step pulse that arrives while the FIFO is full with no pop is dropped.
  - run_mode=1 goes to RUN.
- HALT: done=1, chip_en=0; outputs hold.
  - start re-enters LOAD and clears cycle_cnt and halt_cause. The FIFO is not flushed.
  - step is ignored.

Retirement (any cycle in RUN or STEP_WAIT with chip_en=1):
- Push {ins, wb} as sampled that cycle into the FIFO.
- cycle_cnt increments by 1.
- If ins==HALT_INS, go to HALT with cause 1. The halt instruction itself is traced and counted.
- Else if the incremented cycle_cnt == MAX_CYCLES, go to HALT with cause 2.
- If both conditions hold, cause 1 wins.

start handling:
- start is ignored unless the state is IDLE or HALT.

Trace FIFO:
- Pop occurs when tr_valid AND tr_ready. Head data is registered and stable while tr_valid=1 and tr_ready=0.
- Simultaneous push and pop when full is legal; occupancy is unchanged and no stall occurs.
- Pointers wrap modulo TRACE_DEPTH.
- tr_count ranges 0..TRACE_DEPTH.
- Pop while empty has no effect.

cycle_cnt:
- Saturates at 65535 (unreachable when MAX_CYCLES is legal).

Test Plan:
- Reset with INT=1 for 2 cycles -> chip_INT=1, chip_en=0, tr_valid=0, cycle_cnt=0, busy=0.
- entry=32'h28, run_mode=1, start pulse, tr_ready=1, no HALT_INS in program -> LOAD for 1 cycle, then 43 consecutive chip_en cycles; done=1, halt_cause=2, cycle_cnt=43, 43 FIFO pops observed.
- Program with HALT_INS as the 5th instruction after entry -> HALT after 5 retirements; halt_cause=1, cycle_cnt=5, last traced tr_ins=32'h0000000C.
- Free-run with tr_ready=0 -> chip_en drops after 8 retirements, tr_count=8. Then tr_ready=1 for 3 cycles -> 3 pops with push-when-full, no stall, and ordering preserved with 9th–11th entries following 1st–8th.
- run_mode=0, three step pulses spaced 4 cycles apart -> exactly 3 chip_en cycles, cycle_cnt=3. Then run_mode=1 -> RUN resumes.
- INT asserted mid-RUN at cycle_cnt=20 -> next cycle IDLE, FIFO empty, cycle_cnt=0. A following start with entry=32'h40 -> chip_entry=32'h40, and LOAD is observed.
